// File: rtl/duty_controller.sv
// Button-driven duty level controller: debounced up/down buttons set a 0..10 target.
// Define DUTY_SOFT_RAMP_EN to ramp the duty level one step per RAMP_TICKS cycles.
module duty_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RAMP_TICKS      = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [3:0] duty_level_o,
  output logic [3:0] target_o,
  output logic       at_target_o
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } deb_state_t;

  localparam logic [15:0] STABLE_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  MAX_LEVEL   = 4'd10;

  // Bit 0 carries the up button, bit 1 the down button.
  logic [1:0]  sync_a;
  logic [1:0]  sync_b;
  deb_state_t  state [2];
  logic [15:0] stable_cnt [2];
  logic [1:0]  press;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {down_i, up_i};
      sync_b <= sync_a;
    end
  end

  // The counter reaching DEBOUNCE_CYCLES-1 marks DEBOUNCE_CYCLES stable samples in total.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        state[i]      <= RELEASED;
        stable_cnt[i] <= '0;
      end
      press <= '0;
    end else begin
      press <= '0;
      for (int i = 0; i < 2; i++) begin
        case (state[i])
          RELEASED: begin
            if (sync_b[i]) begin
              state[i]      <= PRESS_CHK;
              stable_cnt[i] <= '0;
            end
          end
          PRESS_CHK: begin
            if (!sync_b[i]) begin
              state[i] <= RELEASED;
            end else begin
              stable_cnt[i] <= stable_cnt[i] + 16'd1;
              if (stable_cnt[i] + 16'd1 == STABLE_LAST) begin
                state[i] <= HELD;
                press[i] <= 1'b1;
              end
            end
          end
          HELD: begin
            if (!sync_b[i]) begin
              state[i]      <= RELEASE_CHK;
              stable_cnt[i] <= '0;
            end
          end
          RELEASE_CHK: begin
            if (sync_b[i]) begin
              state[i] <= HELD;
            end else begin
              stable_cnt[i] <= stable_cnt[i] + 16'd1;
              if (stable_cnt[i] + 16'd1 == STABLE_LAST) begin
                state[i] <= RELEASED;
              end
            end
          end
          default: state[i] <= RELEASED;
        endcase
      end
    end
  end

  // Simultaneous up and down presses cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      target_o <= '0;
    end else if (press == 2'b01 && target_o != MAX_LEVEL) begin
      target_o <= target_o + 4'd1;
    end else if (press == 2'b10 && target_o != 4'd0) begin
      target_o <= target_o - 4'd1;
    end
  end

`ifdef DUTY_SOFT_RAMP_EN
  localparam int TICK_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_TICKS - 1);

  logic [TICK_W-1:0] tick;
  logic              step;

  assign step = (tick == TICK_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || step) begin
      tick <= '0;
    end else begin
      tick <= tick + TICK_W'(1);
    end
  end

  // Uses the registered target, so a target change on a step edge waits for the next step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_level_o <= '0;
    end else if (step && duty_level_o < target_o) begin
      duty_level_o <= duty_level_o + 4'd1;
    end else if (step && duty_level_o > target_o) begin
      duty_level_o <= duty_level_o - 4'd1;
    end
  end
`else
  logic [7:0] unused_ramp_ticks;
  assign unused_ramp_ticks = 8'(RAMP_TICKS);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_level_o <= '0;
    end else begin
      duty_level_o <= target_o;
    end
  end
`endif

  assign at_target_o = (duty_level_o == target_o);

endmodule

// File: tb/tb_duty_controller.sv
// Self-checking bench for duty_controller: directed tables, corner sequences and
// randomized button activity checked every cycle against a behavioural model.
module tb_duty_controller;

  localparam int DEB = 4;
  localparam int RT  = 10;

  logic       clk;
  logic       rst_i;
  logic       up_i;
  logic       down_i;
  logic [3:0] duty_level_o;
  logic [3:0] target_o;
  logic       at_target_o;

  int checks = 0;
  int errors = 0;
  bit modelOn = 0;

  // Behavioural model state
  int edgeCount = 0;
  int mTarget   = 0;
  int mDuty     = 0;
  int accLevel [2];
  int runLen [2];
  int upDue [$];
  int downDue [$];

  typedef struct {
    logic up;
    logic down;
    int   hold;
    int   expTarget;
  } vec_t;

  vec_t vecs [$];

  duty_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .RAMP_TICKS     (RT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .up_i        (up_i),
    .down_i      (down_i),
    .duty_level_o(duty_level_o),
    .target_o    (target_o),
    .at_target_o (at_target_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic u, input logic d, input int n);
    up_i   = u;
    down_i = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    up_i   = 1'b0;
    down_i = 1'b0;
    rst_i  = 1'b1;
    @(negedge clk);
    rst_i  = 1'b0;
  endtask

  task automatic pressUp(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 5);
      applyStimulus(1'b0, 1'b0, 5);
    end
  endtask

  task automatic waitDuty(input int want, input int budget);
    int k;
    k = 0;
    while (duty_level_o !== 4'(want) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("wait_duty", duty_level_o, 4'(want));
  endtask

  // A button's accepted level flips after DEB consecutive samples of the opposite level;
  // returns 1 when the flip is a new press.
  function automatic bit dbSample(input int b, input int r);
    if (r == accLevel[b]) begin
      runLen[b] = 0;
      return 1'b0;
    end
    runLen[b]++;
    if (runLen[b] < DEB) return 1'b0;
    accLevel[b] = r;
    runLen[b]   = 0;
    return (r == 1);
  endfunction

  // Press accepted from the raw sample taken at edge e changes the target at edge e+3.
  always @(posedge clk) begin
    bit upP;
    bit dnP;
    if (rst_i) begin
      edgeCount = 0;
      mTarget   = 0;
      mDuty     = 0;
      for (int b = 0; b < 2; b++) begin
        accLevel[b] = 0;
        runLen[b]   = 0;
      end
      upDue.delete();
      downDue.delete();
    end else begin
      edgeCount++;
      upP = (upDue.size() > 0 && upDue[0] == edgeCount);
      if (upP) void'(upDue.pop_front());
      dnP = (downDue.size() > 0 && downDue[0] == edgeCount);
      if (dnP) void'(downDue.pop_front());
`ifdef DUTY_SOFT_RAMP_EN
      if (edgeCount % RT == 0) begin
        if (mDuty < mTarget) mDuty++;
        else if (mDuty > mTarget) mDuty--;
      end
`else
      mDuty = mTarget;
`endif
      if (upP && !dnP && mTarget < 10) mTarget++;
      else if (dnP && !upP && mTarget > 0) mTarget--;
      if (dbSample(0, int'(up_i))) upDue.push_back(edgeCount + 3);
      if (dbSample(1, int'(down_i))) downDue.push_back(edgeCount + 3);
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("model_target", target_o, 4'(mTarget));
      checkOutput("model_duty", duty_level_o, 4'(mDuty));
      checkOutput("model_at_target", {3'b000, at_target_o}, {3'b000, (mDuty == mTarget)});
    end
  end

  initial begin
    int   firstK;
    int   lowCount;
    int   dutyAtChange;
    int   len;
    int   kind;
    logic u;
    logic d;
    logic [3:0] prevDuty;
    int   stepCycle [$];
    int   stepVal [$];
    int   stepAt [$];

    // Table: saturation at 10 and 0, plus simultaneous presses at the limits and mid-range.
    for (int i = 1; i <= 12; i++) vecs.push_back('{1'b1, 1'b0, 8, (i > 10) ? 10 : i});
    vecs.push_back('{1'b1, 1'b0, 8, 10});
    vecs.push_back('{1'b1, 1'b1, 20, 10});
    for (int i = 1; i <= 11; i++) vecs.push_back('{1'b0, 1'b1, 8, (10 - i < 0) ? 0 : 10 - i});
    vecs.push_back('{1'b1, 1'b1, 20, 0});
    vecs.push_back('{1'b1, 1'b0, 8, 1});
    vecs.push_back('{1'b1, 1'b1, 20, 1});

    rst_i  = 1'b1;
    up_i   = 1'b0;
    down_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    modelOn = 1;
    rst_i   = 1'b0;

    checkOutput("reset_duty", duty_level_o, 4'd0);
    checkOutput("reset_target", target_o, 4'd0);
    checkOutput("reset_at_target", {3'b000, at_target_o}, 4'd1);

    // Short glitch is rejected, long hold gives one increment after DEB+3 edges.
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("glitch_target", target_o, 4'd0);
    up_i   = 1'b1;
    firstK = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (target_o == 4'd1 && firstK == 0) firstK = k;
    end
    checkOutput("press_latency", 4'(firstK), 4'(DEB + 3));
    checkOutput("no_repeat_target", target_o, 4'd1);
    applyStimulus(1'b0, 1'b0, 10);

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].up, vecs[i].down, vecs[i].hold);
      applyStimulus(1'b0, 1'b0, 8);
      checkOutput("table_target", target_o, 4'(vecs[i].expTarget));
    end

`ifdef DUTY_SOFT_RAMP_EN
    // Three quick presses: duty follows in single steps exactly RT cycles apart.
    doReset();
    prevDuty = 4'd0;
    for (int k = 0; k < 80; k++) begin
      up_i = (k < 30) && ((k % 10) < 5);
      @(negedge clk);
      if (duty_level_o != prevDuty) begin
        stepCycle.push_back(k);
        stepVal.push_back(int'(duty_level_o));
        stepAt.push_back(int'(at_target_o));
        prevDuty = duty_level_o;
      end
    end
    checkOutput("ramp_step_count", 4'(stepCycle.size()), 4'd3);
    if (stepCycle.size() == 3) begin
      for (int i = 0; i < 3; i++) checkOutput("ramp_step_value", 4'(stepVal[i]), 4'(i + 1));
      checkOutput("ramp_gap1", 4'(stepCycle[1] - stepCycle[0]), 4'(RT));
      checkOutput("ramp_gap2", 4'(stepCycle[2] - stepCycle[1]), 4'(RT));
      checkOutput("ramp_at_target_third", 4'(stepAt[2]), 4'd1);
    end
`else
    // Direct load: duty follows the target one edge later, at_target low for one cycle.
    doReset();
    pressUp(2);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("direct_pre_target", target_o, 4'd2);
    lowCount     = 0;
    dutyAtChange = -1;
    for (int k = 0; k < 20; k++) begin
      up_i = (k < 6);
      @(negedge clk);
      if (at_target_o == 1'b0) lowCount++;
      if (target_o == 4'd3 && dutyAtChange < 0) dutyAtChange = int'(duty_level_o);
    end
    checkOutput("direct_duty_at_change", 4'(dutyAtChange), 4'd2);
    checkOutput("direct_low_cycles", 4'(lowCount), 4'd1);
    checkOutput("direct_final_duty", duty_level_o, 4'd3);
`endif

    // Reset during a ramp and a debounce: everything clears, the held button starts over.
    doReset();
    pressUp(5);
    waitDuty(5, 200);
    applyStimulus(1'b1, 1'b0, 3);
    rst_i = 1'b1;
    @(negedge clk);
    checkOutput("midreset_duty", duty_level_o, 4'd0);
    checkOutput("midreset_target", target_o, 4'd0);
    checkOutput("midreset_at_target", {3'b000, at_target_o}, 4'd1);
    rst_i  = 1'b0;
    firstK = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (target_o == 4'd1 && firstK == 0) firstK = k;
    end
    checkOutput("postreset_latency", 4'(firstK), 4'(DEB + 3));
    applyStimulus(1'b0, 1'b0, 10);

    // Randomized button activity with occasional resets, checked by the model every cycle.
    doReset();
    for (int s = 0; s < 250; s++) begin
      len  = int'($urandom_range(1, 14));
      kind = int'($urandom_range(0, 39));
      if (kind == 0) begin
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
      end
      u = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0);
      applyStimulus(u, d, len);
    end
    applyStimulus(1'b0, 1'b0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
